// File: rtl/rst_seq_pkg.sv
// Shared state encoding and parameter defaults for the reset sequencer.
package rst_seq_pkg;

   typedef enum logic [2:0] {
      HOLD      = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      CORE_REL  = 3'd3,
      RUN       = 3'd4
   } state_t;

   localparam int LOCK_WAIT_CYCLES_DEF = 16;
   localparam int STAGE_DELAY_DEF      = 4;
   localparam int DEBOUNCE_CYCLES_DEF  = 8;
   localparam logic [7:0] LOSS_MAX     = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rst_sequencer.sv
// Staged core/peripheral reset release gated on a stable PLL lock, with
// pushbutton debounce and a saturating lock-loss counter.
//
// state     | meaning
// ----------+------------------------------------------------------
// HOLD      | just out of reset, everything held
// WAIT_LOCK | waiting for lock and button both high
// STABLE    | counting consecutive good lock cycles
// CORE_REL  | core released, waiting to release peripherals
// RUN       | sequence complete, all resets released
module rst_sequencer
   import rst_seq_pkg::*;
#(
   parameter int LOCK_WAIT_CYCLES = LOCK_WAIT_CYCLES_DEF,
   parameter int STAGE_DELAY      = STAGE_DELAY_DEF,
   parameter int DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       PLL_LOCK,
   input  logic       EXT_RST_N,
   output logic       CORE_RESETN,
   output logic       PERIPH_RESETN,
   output logic       READY,
   output logic [2:0] STATE,
   output logic [7:0] LOCK_LOSS_CNT
);

   localparam int LW = $clog2(LOCK_WAIT_CYCLES) + 1;
   localparam int SW = $clog2(STAGE_DELAY) + 1;
   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;

   localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_WAIT_CYCLES - 1);
   localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_DELAY - 1);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE_CYCLES);

   state_t          state;
   logic            lock_s;
   logic            ext_s;
   logic            press;
   logic [LW-1:0]   lock_cnt;
   logic [SW-1:0]   stage_cnt;
   logic [DW-1:0]   deb_cnt;

   sync_2ff u_sync_lock (
      .clk   (CLK),
      .rst_n (RESETN),
      .d     (PLL_LOCK),
      .q     (lock_s)
   );

   sync_2ff u_sync_ext (
      .clk   (CLK),
      .rst_n (RESETN),
      .d     (EXT_RST_N),
      .q     (ext_s)
   );

   // Debounce count saturates so a held button raises exactly one press.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         deb_cnt <= '0;
      end else if (ext_s) begin
         deb_cnt <= '0;
      end else if (deb_cnt != DEB_MAX) begin
         deb_cnt <= deb_cnt + 1'b1;
      end
   end

   assign press = !ext_s && (deb_cnt == DEB_LAST);

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state         <= HOLD;
         lock_cnt      <= '0;
         stage_cnt     <= '0;
         CORE_RESETN   <= 1'b0;
         PERIPH_RESETN <= 1'b0;
         READY         <= 1'b0;
         LOCK_LOSS_CNT <= '0;
      end else begin
         case (state)
            HOLD: begin
               state <= WAIT_LOCK;
            end
            WAIT_LOCK: begin
               if (lock_s && ext_s) begin
                  state    <= STABLE;
                  lock_cnt <= '0;
               end
            end
            STABLE: begin
               if (!lock_s || !ext_s) begin
                  state <= WAIT_LOCK;
               end else if (lock_cnt == LOCK_LAST) begin
                  state       <= CORE_REL;
                  stage_cnt   <= '0;
                  CORE_RESETN <= 1'b1;
               end else begin
                  lock_cnt <= lock_cnt + 1'b1;
               end
            end
            CORE_REL, RUN: begin
               // Lock loss and press collapse into one transition; only a
               // lock loss while running is counted.
               if (!lock_s || press) begin
                  state         <= WAIT_LOCK;
                  CORE_RESETN   <= 1'b0;
                  PERIPH_RESETN <= 1'b0;
                  READY         <= 1'b0;
                  if (state == RUN && !lock_s && LOCK_LOSS_CNT != LOSS_MAX) begin
                     LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 1'b1;
                  end
               end else if (state == CORE_REL) begin
                  if (stage_cnt == STAGE_LAST) begin
                     state         <= RUN;
                     PERIPH_RESETN <= 1'b1;
                     READY         <= 1'b1;
                  end else begin
                     stage_cnt <= stage_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state         <= HOLD;
               CORE_RESETN   <= 1'b0;
               PERIPH_RESETN <= 1'b0;
               READY         <= 1'b0;
            end
         endcase
      end
   end

   assign STATE = state;

endmodule
